// File: rtl/apb_regs_pkg.sv
// Shared types for the APB slave controller: FSM states, address classes, counter width.
package apb_regs_pkg;

  localparam int unsigned CntW = 4;

  typedef enum logic [0:0] {
    StIdle,
    StAccess
  } apb_state_e;

  typedef enum logic [1:0] {
    ClsRw,
    ClsRo,
    ClsErr
  } addr_cls_e;

endpackage

// File: rtl/apb_addr_class.sv
// Combinational address decoder: classifies an APB address as RW, RO or error
// and returns the register index within its class.
module apb_addr_class
  import apb_regs_pkg::*;
#(
  parameter int unsigned AWIDTH           = 4,
  parameter int unsigned REGWN            = 5,
  parameter int unsigned REGRN            = 3,
  parameter int unsigned REGR_ADDR_OFFSET = 5
) (
  input  logic [AWIDTH-1:0] addr_i,
  input  logic              write_i,
  output addr_cls_e         cls_o,
  output logic [AWIDTH-1:0] idx_o
);

  always_comb begin
    cls_o = ClsErr;
    idx_o = '0;
    if (32'(addr_i) < REGWN) begin
      cls_o = ClsRw;
      idx_o = addr_i;
    end else if (32'(addr_i) >= REGR_ADDR_OFFSET &&
                 32'(addr_i) < REGR_ADDR_OFFSET + REGRN && !write_i) begin
      // Writes to status registers fall through to the error class.
      cls_o = ClsRo;
      idx_o = addr_i - AWIDTH'(REGR_ADDR_OFFSET);
    end
  end

endmodule

// File: rtl/apb_slave_ctrl.sv
// APB slave transfer controller: sequences SETUP/ACCESS with wait states and
// drives register-bank strobes, read mux and the APB response.
module apb_slave_ctrl
  import apb_regs_pkg::*;
#(
  parameter int unsigned AWIDTH           = 4,
  parameter int unsigned DWIDTH           = 32,
  parameter int unsigned REGWN            = 5,
  parameter int unsigned REGRN            = 3,
  parameter int unsigned REGR_ADDR_OFFSET = 5,
  parameter int unsigned WAIT_STATES      = 1
) (
  input  logic                    pclk_i,
  input  logic                    preset_i,
  input  logic                    psel_i,
  input  logic                    penable_i,
  input  logic                    pwrite_i,
  input  logic [AWIDTH-1:0]       paddr_i,
  input  logic [DWIDTH-1:0]       pwdata_i,
  output logic [DWIDTH-1:0]       prdata_o,
  output logic                    pready_o,
  output logic                    pslverr_o,
  output logic [REGWN-1:0]        reg_we_o,
  output logic [DWIDTH-1:0]       reg_wdata_o,
  input  logic [REGWN*DWIDTH-1:0] rw_rdata_i,
  input  logic [REGRN*DWIDTH-1:0] ro_rdata_i,
  output logic [REGRN-1:0]        ro_rd_o
);

  apb_state_e        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  addr_cls_e         cls_q, cls_d, cls_w;
  logic [AWIDTH-1:0] idx_q, idx_d, idx_w;
  logic              write_q, write_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d;

  apb_addr_class #(
    .AWIDTH          (AWIDTH),
    .REGWN           (REGWN),
    .REGRN           (REGRN),
    .REGR_ADDR_OFFSET(REGR_ADDR_OFFSET)
  ) u_addr_class (
    .addr_i (paddr_i),
    .write_i(pwrite_i),
    .cls_o  (cls_w),
    .idx_o  (idx_w)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cls_d   = cls_q;
    idx_d   = idx_q;
    write_d = write_q;
    wdata_d = wdata_q;
    unique case (state_q)
      StIdle: begin
        if (psel_i && !penable_i) begin
          state_d = StAccess;
          cnt_d   = CntW'(WAIT_STATES);
          cls_d   = cls_w;
          idx_d   = idx_w;
          write_d = pwrite_i;
          wdata_d = pwdata_i;
        end
      end
      StAccess: begin
        // Completion and master abort both end the transfer.
        if (cnt_q == '0 || !(psel_i && penable_i)) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge pclk_i or posedge preset_i) begin
    if (preset_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      cls_q   <= ClsRw;
      idx_q   <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cls_q   <= cls_d;
      idx_q   <= idx_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
    end
  end

  assign pready_o    = (state_q == StAccess) && (cnt_q == '0);
  assign reg_wdata_o = wdata_q;

  // Strobes and read data live only in the completion cycle.
  always_comb begin
    prdata_o  = '0;
    pslverr_o = 1'b0;
    reg_we_o  = '0;
    ro_rd_o   = '0;
    if (pready_o) begin
      unique case (cls_q)
        ClsRw: begin
          for (int i = 0; i < int'(REGWN); i++) begin
            if (idx_q == AWIDTH'(i)) begin
              if (write_q) reg_we_o[i] = 1'b1;
              else         prdata_o    = rw_rdata_i[i*DWIDTH +: DWIDTH];
            end
          end
        end
        ClsRo: begin
          for (int i = 0; i < int'(REGRN); i++) begin
            if (idx_q == AWIDTH'(i)) begin
              ro_rd_o[i] = 1'b1;
              prdata_o   = ro_rdata_i[i*DWIDTH +: DWIDTH];
            end
          end
        end
        ClsErr:  pslverr_o = 1'b1;
        default: pslverr_o = 1'b0;
      endcase
    end
  end

endmodule
